// File: rtl/led_pkg.sv
// Shared definitions for the LED bar-graph pattern monitor: level codes,
// FSM states, error causes and the step-legality helpers.
package led_pkg;

    localparam logic [4:0] CODE_L0 = 5'b00000;
    localparam logic [4:0] CODE_L1 = 5'b00001;
    localparam logic [4:0] CODE_L2 = 5'b00111;
    localparam logic [4:0] CODE_L3 = 5'b01111;
    localparam logic [4:0] CODE_L4 = 5'b11111;

    localparam logic [2:0] LEVEL_MAX = 3'd4;

    typedef enum logic [2:0] {
        ST_SEARCH   = 3'd0,
        ST_CONF_BLK = 3'd1,
        ST_CONF_LVL = 3'd2,
        ST_LOCK_BLK = 3'd3,
        ST_LOCK_LVL = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_BLANK = 2'b01,
        ERR_CODE  = 2'b10,
        ERR_STEP  = 2'b11
    } err_code_e;

    // True for a single-level move, or the L4->L0 rollover when wrapping is allowed.
    function automatic logic step_ok(input logic [2:0] old_lvl,
                                     input logic [2:0] new_lvl,
                                     input logic       allow_wrap);
        logic adjacent;
        logic wrap;
        adjacent = (new_lvl == old_lvl + 3'd1) || (old_lvl == new_lvl + 3'd1);
        wrap     = allow_wrap && (old_lvl == LEVEL_MAX) && (new_lvl == 3'd0);
        return adjacent || wrap;
    endfunction

    // A rollover counts as upward movement.
    function automatic logic step_up(input logic [2:0] old_lvl,
                                     input logic [2:0] new_lvl);
        return (new_lvl > old_lvl) || ((old_lvl == LEVEL_MAX) && (new_lvl == 3'd0));
    endfunction

endpackage

// File: rtl/led_code_decode.sv
// Combinational thermometer-code decoder: 5-bit LED pattern to level 0..4
// plus a legal flag. Illegal patterns report level 0.
module led_code_decode
    import led_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [2:0] level_o,
    output logic       legal_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        level_o = 3'd0;
        legal_o = 1'b1;
        case (code_i)
            CODE_L0: level_o = 3'd0;
            CODE_L1: level_o = 3'd1;
            CODE_L2: level_o = 3'd2;
            CODE_L3: level_o = 3'd3;
            CODE_L4: level_o = 3'd4;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pattern_monitor.sv
// Tracks an LED display that alternates blank frames with bar-graph levels,
// locking onto the pattern and flagging blank, code and step violations.
module led_pattern_monitor
    import led_pkg::*;
#(
    parameter bit ALLOW_WRAP = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       led0,
    input  logic [3:0] leds_hi,
    output logic [2:0] level,
    output logic       level_valid,
    output logic       dir,
    output logic       locked,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic [7:0] err_count
);

    logic [4:0] code;
    logic [2:0] code_level;
    logic       code_legal;
    logic       code_blank;

    assign code       = {leds_hi, led0};
    assign code_blank = (code == CODE_L0);

    led_code_decode u_decode (
        .code_i  (code),
        .level_o (code_level),
        .legal_o (code_legal)
    );

    state_e    state_q,       state_d;
    logic [2:0] cand_q,       cand_d;
    logic [2:0] level_q,      level_d;
    logic       dir_q,        dir_d;
    logic       locked_q,     locked_d;
    logic       level_valid_q, level_valid_d;
    logic       err_pulse_q,  err_pulse_d;
    err_code_e  err_code_q,   err_code_d;
    logic [7:0] err_count_q,  err_count_d;

    logic       raise_err;
    err_code_e  raise_code;

    // Candidate level from the search phase is kept apart from the reported
    // level, which only moves on an accepted step.
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        level_d       = level_q;
        dir_d         = dir_q;
        locked_d      = locked_q;
        level_valid_d = 1'b0;
        raise_err     = 1'b0;
        raise_code    = ERR_NONE;

        case (state_q)
            ST_SEARCH: begin
                if (code_legal && !code_blank) begin
                    cand_d  = code_level;
                    state_d = ST_CONF_BLK;
                end
            end

            ST_CONF_BLK: begin
                state_d = code_blank ? ST_CONF_LVL : ST_SEARCH;
            end

            ST_CONF_LVL: begin
                if (code_legal && step_ok(cand_q, code_level, ALLOW_WRAP)) begin
                    level_d  = code_level;
                    dir_d    = step_up(cand_q, code_level);
                    locked_d = 1'b1;
                    state_d  = ST_LOCK_BLK;
                end else begin
                    state_d  = ST_SEARCH;
                end
            end

            ST_LOCK_BLK: begin
                if (code_blank) begin
                    state_d    = ST_LOCK_LVL;
                end else begin
                    raise_err  = 1'b1;
                    raise_code = ERR_BLANK;
                    locked_d   = 1'b0;
                    state_d    = ST_SEARCH;
                end
            end

            ST_LOCK_LVL: begin
                if (!code_legal) begin
                    raise_err  = 1'b1;
                    raise_code = ERR_CODE;
                    locked_d   = 1'b0;
                    state_d    = ST_SEARCH;
                end else if (!step_ok(level_q, code_level, ALLOW_WRAP)) begin
                    raise_err  = 1'b1;
                    raise_code = ERR_STEP;
                    locked_d   = 1'b0;
                    state_d    = ST_SEARCH;
                end else begin
                    level_d       = code_level;
                    dir_d         = step_up(level_q, code_level);
                    level_valid_d = 1'b1;
                    state_d       = ST_LOCK_BLK;
                end
            end

            default: begin
                locked_d = 1'b0;
                state_d  = ST_SEARCH;
            end
        endcase

        err_pulse_d = raise_err;
        err_code_d  = raise_err ? raise_code : err_code_q;
        err_count_d = (raise_err && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= ST_SEARCH;
            cand_q        <= 3'd0;
            level_q       <= 3'd0;
            dir_q         <= 1'b0;
            locked_q      <= 1'b0;
            level_valid_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            err_count_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            level_q       <= level_d;
            dir_q         <= dir_d;
            locked_q      <= locked_d;
            level_valid_q <= level_valid_d;
            err_pulse_q   <= err_pulse_d;
            err_code_q    <= err_code_d;
            err_count_q   <= err_count_d;
        end
    end

    assign level       = level_q;
    assign level_valid = level_valid_q;
    assign dir         = dir_q;
    assign locked      = locked_q;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Directed bench for led_pattern_monitor: a vector table for the main walk,
// plus hand sequences for no-wrap, saturation and mid-run reset.
module tb_led_pattern_monitor;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       led0 = 1'b0;
    logic [3:0] leds_hi = 4'd0;

    logic [2:0] level,     n_level;
    logic       level_valid, n_level_valid;
    logic       dir,       n_dir;
    logic       locked,    n_locked;
    logic       err_pulse, n_err_pulse;
    logic [1:0] err_code,  n_err_code;
    logic [7:0] err_count, n_err_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    led_pattern_monitor #(.ALLOW_WRAP(1'b1)) dut (
        .clock       (clock),
        .reset       (reset),
        .led0        (led0),
        .leds_hi     (leds_hi),
        .level       (level),
        .level_valid (level_valid),
        .dir         (dir),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .err_count   (err_count)
    );

    led_pattern_monitor #(.ALLOW_WRAP(1'b0)) dut_nowrap (
        .clock       (clock),
        .reset       (reset),
        .led0        (led0),
        .leds_hi     (leds_hi),
        .level       (n_level),
        .level_valid (n_level_valid),
        .dir         (n_dir),
        .locked      (n_locked),
        .err_pulse   (n_err_pulse),
        .err_code    (n_err_code),
        .err_count   (n_err_count)
    );

    typedef struct {
        logic [4:0] c;
        logic [2:0] level;
        logic       lv;
        logic       dir;
        logic       locked;
        logic       ep;
        logic [1:0] ec;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[34];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one sample before the edge; outputs are read 1 time unit after it.
    task automatic step(input logic [4:0] c, input logic rst);
        @(negedge clock);
        {leds_hi, led0} = c;
        reset = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".level"},  32'(level),       32'(v.level));
        check({tag, ".lv"},     32'(level_valid), 32'(v.lv));
        check({tag, ".dir"},    32'(dir),         32'(v.dir));
        check({tag, ".locked"}, 32'(locked),      32'(v.locked));
        check({tag, ".ep"},     32'(err_pulse),   32'(v.ep));
        check({tag, ".ec"},     32'(err_code),    32'(v.ec));
        check({tag, ".cnt"},    32'(err_count),   32'(v.cnt));
    endtask

    function automatic vec_t mk(input logic [4:0] c, input logic [2:0] lvl, input logic lv,
                                input logic d, input logic lk, input logic ep,
                                input logic [1:0] ec, input logic [7:0] cnt);
        vec_t v;
        v.c = c; v.level = lvl; v.lv = lv; v.dir = d; v.locked = lk;
        v.ep = ep; v.ec = ec; v.cnt = cnt;
        return v;
    endfunction

    vec_t zero_v;

    initial begin
        //              code      lvl lv dir lk ep ec     cnt
        vecs[0]  = mk(5'b00001, 3'd0, 0, 0, 0, 0, 2'b00, 8'd0);
        vecs[1]  = mk(5'b00000, 3'd0, 0, 0, 0, 0, 2'b00, 8'd0);
        vecs[2]  = mk(5'b00111, 3'd2, 0, 1, 1, 0, 2'b00, 8'd0);
        vecs[3]  = mk(5'b00000, 3'd2, 0, 1, 1, 0, 2'b00, 8'd0);
        vecs[4]  = mk(5'b01111, 3'd3, 1, 1, 1, 0, 2'b00, 8'd0);
        vecs[5]  = mk(5'b00000, 3'd3, 0, 1, 1, 0, 2'b00, 8'd0);
        vecs[6]  = mk(5'b11111, 3'd4, 1, 1, 1, 0, 2'b00, 8'd0);
        vecs[7]  = mk(5'b00000, 3'd4, 0, 1, 1, 0, 2'b00, 8'd0);
        vecs[8]  = mk(5'b00000, 3'd0, 1, 1, 1, 0, 2'b00, 8'd0);
        vecs[9]  = mk(5'b00000, 3'd0, 0, 1, 1, 0, 2'b00, 8'd0);
        vecs[10] = mk(5'b00001, 3'd1, 1, 1, 1, 0, 2'b00, 8'd0);
        vecs[11] = mk(5'b00000, 3'd1, 0, 1, 1, 0, 2'b00, 8'd0);
        vecs[12] = mk(5'b00000, 3'd0, 1, 0, 1, 0, 2'b00, 8'd0);
        vecs[13] = mk(5'b00000, 3'd0, 0, 0, 1, 0, 2'b00, 8'd0);
        vecs[14] = mk(5'b00001, 3'd1, 1, 1, 1, 0, 2'b00, 8'd0);
        vecs[15] = mk(5'b00011, 3'd1, 0, 1, 0, 1, 2'b01, 8'd1);
        vecs[16] = mk(5'b00011, 3'd1, 0, 1, 0, 0, 2'b01, 8'd1);
        vecs[17] = mk(5'b00001, 3'd1, 0, 1, 0, 0, 2'b01, 8'd1);
        vecs[18] = mk(5'b00000, 3'd1, 0, 1, 0, 0, 2'b01, 8'd1);
        vecs[19] = mk(5'b00111, 3'd2, 0, 1, 1, 0, 2'b01, 8'd1);
        vecs[20] = mk(5'b00000, 3'd2, 0, 1, 1, 0, 2'b01, 8'd1);
        vecs[21] = mk(5'b00101, 3'd2, 0, 1, 0, 1, 2'b10, 8'd2);
        vecs[22] = mk(5'b00011, 3'd2, 0, 1, 0, 0, 2'b10, 8'd2);
        vecs[23] = mk(5'b00001, 3'd2, 0, 1, 0, 0, 2'b10, 8'd2);
        vecs[24] = mk(5'b00000, 3'd2, 0, 1, 0, 0, 2'b10, 8'd2);
        vecs[25] = mk(5'b00111, 3'd2, 0, 1, 1, 0, 2'b10, 8'd2);
        vecs[26] = mk(5'b00000, 3'd2, 0, 1, 1, 0, 2'b10, 8'd2);
        vecs[27] = mk(5'b00111, 3'd2, 0, 1, 0, 1, 2'b11, 8'd3);
        vecs[28] = mk(5'b01111, 3'd2, 0, 1, 0, 0, 2'b11, 8'd3);
        vecs[29] = mk(5'b11111, 3'd2, 0, 1, 0, 0, 2'b11, 8'd3);
        vecs[30] = mk(5'b11111, 3'd2, 0, 1, 0, 0, 2'b11, 8'd3);
        vecs[31] = mk(5'b00000, 3'd2, 0, 1, 0, 0, 2'b11, 8'd3);
        vecs[32] = mk(5'b00001, 3'd2, 0, 1, 0, 0, 2'b11, 8'd3);
        vecs[33] = mk(5'b00000, 3'd2, 0, 1, 0, 0, 2'b11, 8'd3);
        zero_v   = mk(5'b00000, 3'd0, 0, 0, 0, 0, 2'b00, 8'd0);

        // Reset state
        step(5'b00000, 1'b1);
        step(5'b00000, 1'b1);
        check_all("reset", zero_v);

        // Main table walk: lock, wrap, down-step, blank/code/step errors, search rejects
        for (int i = 0; i < 34; i++) begin
            step(vecs[i].c, 1'b0);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // No-wrap instance: L4 -> L0 is an illegal step
        step(5'b00000, 1'b1);
        for (int i = 0; i < 8; i++) step(vecs[i].c, 1'b0);
        check("nowrap.pre_level", 32'(n_level), 32'd4);
        step(5'b00000, 1'b0);
        check("nowrap.ec",     32'(n_err_code),  32'd3);
        check("nowrap.locked", 32'(n_locked),    32'd0);
        check("nowrap.ep",     32'(n_err_pulse), 32'd1);
        check("nowrap.level",  32'(n_level),     32'd4);
        check("wrap.level",    32'(level),       32'd0);
        check("wrap.lv",       32'(level_valid), 32'd1);
        check("wrap.dir",      32'(dir),         32'd1);

        // Saturation: 300 blank-missing errors
        step(5'b00000, 1'b1);
        for (int e = 1; e <= 300; e++) begin
            step(5'b00001, 1'b0);
            step(5'b00000, 1'b0);
            step(5'b00111, 1'b0);
            step(5'b00011, 1'b0);
            if (e == 254) check("sat.254", 32'(err_count), 32'd254);
            if (e == 255) check("sat.255", 32'(err_count), 32'd255);
        end
        check("sat.300",    32'(err_count), 32'd255);
        check("sat.ep",     32'(err_pulse), 32'd1);
        step(5'b00000, 1'b0);
        check("sat.hold",   32'(err_count), 32'd255);
        check("sat.ep_off", 32'(err_pulse), 32'd0);

        // Mid-run reset with count 5 while locked, coinciding with a would-be error
        step(5'b00000, 1'b1);
        for (int e = 0; e < 5; e++) begin
            step(5'b00001, 1'b0);
            step(5'b00000, 1'b0);
            step(5'b00111, 1'b0);
            step(5'b00011, 1'b0);
        end
        step(5'b00001, 1'b0);
        step(5'b00000, 1'b0);
        step(5'b00111, 1'b0);
        check("rst.pre_cnt",    32'(err_count), 32'd5);
        check("rst.pre_locked", 32'(locked),    32'd1);
        step(5'b00011, 1'b1);
        check_all("rst.mid", zero_v);
        step(5'b00001, 1'b0);
        step(5'b00000, 1'b0);
        check("relock.not_yet", 32'(locked), 32'd0);
        step(5'b00111, 1'b0);
        check("relock.locked", 32'(locked), 32'd1);
        check("relock.level",  32'(level),  32'd2);
        check("relock.cnt",    32'(err_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
